// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate-bank checker: y bit layout, vector count,
// FSM encoding and the golden expected-response function.
package gate_check_pkg;

  localparam int unsigned NUM_VECTORS = 4;
  localparam int unsigned Y_WIDTH     = 7;

  localparam int unsigned Y_AND   = 0;
  localparam int unsigned Y_OR    = 1;
  localparam int unsigned Y_NAND  = 2;
  localparam int unsigned Y_NOR   = 3;
  localparam int unsigned Y_XOR   = 4;
  localparam int unsigned Y_XNOR  = 5;
  localparam int unsigned Y_NOT_A = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic [Y_WIDTH-1:0] expected_y(input logic a, input logic b);
    logic [Y_WIDTH-1:0] y;
    y          = '0;
    y[Y_AND]   = a & b;
    y[Y_OR]    = a | b;
    y[Y_NAND]  = ~(a & b);
    y[Y_NOR]   = ~(a | b);
    y[Y_XOR]   = a ^ b;
    y[Y_XNOR]  = ~(a ^ b);
    y[Y_NOT_A] = ~a;
    return y;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Golden combinational response of a correct gate bank for operands a, b.
module gate_ref_model
  import gate_check_pkg::*;
(
  input  logic               a,
  input  logic               b,
  output logic [Y_WIDTH-1:0] y
);

  assign y = expected_y(a, b);

endmodule

// File: rtl/gate_checker.sv
// Walks the four (a,b) vectors through an external gate bank and scores its responses.
// Optional GATE_CHECKER_BITMASK_EN adds fail_bits_out, the per-gate failure mask.
module gate_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start_in,
  input  logic [6:0]   y_in,
  output logic         a_out,
  output logic         b_out,
  output logic         busy_out,
  output logic         done_out,
  output logic         pass_out,
  output logic [2:0]   err_count_out,
  output logic [3:0]   fail_vec_out
`ifdef GATE_CHECKER_BITMASK_EN
  ,
  output logic [6:0]   fail_bits_out
`endif
);

  localparam logic [3:0] LastCnt = 4'(SETTLE_CYCLES);
  localparam logic [1:0] LastVec = 2'(NUM_VECTORS - 1);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fvec_q, fvec_d;
  logic       pass_q, pass_d;
`ifdef GATE_CHECKER_BITMASK_EN
  logic [6:0] fbits_q, fbits_d;
`endif

  logic [Y_WIDTH-1:0] y_exp;
  logic [Y_WIDTH-1:0] diff;
  logic               vec_fail;

  gate_ref_model u_ref (
    .a (a_out),
    .b (b_out),
    .y (y_exp)
  );

  assign diff     = y_in ^ y_exp;
  assign vec_fail = |diff;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    pass_d  = pass_q;
`ifdef GATE_CHECKER_BITMASK_EN
    fbits_d = fbits_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d = StRun;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fvec_d  = '0;
          pass_d  = 1'b0;
`ifdef GATE_CHECKER_BITMASK_EN
          fbits_d = '0;
`endif
        end
      end
      StRun: begin
        // Last edge of the hold window: score this vector and advance on the same edge.
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
          vec_d = vec_q + 2'd1;
          if (vec_fail) begin
            err_d         = err_q + 3'd1;
            fvec_d[vec_q] = 1'b1;
          end
`ifdef GATE_CHECKER_BITMASK_EN
          fbits_d = fbits_q | diff;
`endif
          if (vec_q == LastVec) begin
            state_d = StDone;
            pass_d  = (err_d == '0);
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fvec_q  <= '0;
      pass_q  <= 1'b0;
`ifdef GATE_CHECKER_BITMASK_EN
      fbits_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      pass_q  <= pass_d;
`ifdef GATE_CHECKER_BITMASK_EN
      fbits_q <= fbits_d;
`endif
    end
  end

  assign busy_out      = (state_q == StRun);
  assign done_out      = (state_q == StDone);
  assign a_out         = busy_out & vec_q[1];
  assign b_out         = busy_out & vec_q[0];
  assign pass_out      = pass_q;
  assign err_count_out = err_q;
  assign fail_vec_out  = fvec_q;
`ifdef GATE_CHECKER_BITMASK_EN
  assign fail_bits_out = fbits_q;
`endif

endmodule

// File: tb/tb_gate_checker.sv
// Randomized self-checking bench: two checkers (SETTLE_CYCLES 2 and 0) driving faultable gate banks.
module tb_gate_checker;

  localparam int P0 = 3;  // hold length with SETTLE_CYCLES=2
  localparam int P1 = 1;  // hold length with SETTLE_CYCLES=0

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] mask [4];
  logic [1:0] a, b, busy, done, pass;
  logic [2:0] errc [2];
  logic [3:0] fvec [2];
  logic [6:0] y [2];
`ifdef GATE_CHECKER_BITMASK_EN
  logic [6:0] fbits [2];
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int t [2] = '{-1, -1};  // cycles since accepted start edge; -1 = idle, nothing run since reset
  logic [6:0] snap [2][4];

  always #5 clk = ~clk;

  function automatic logic [6:0] gold(input logic ga, input logic gb);
    return {~ga, ~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ga | gb, ga & gb};
  endfunction

  function automatic int per(input int k);
    return (k == 0) ? P0 : P1;
  endfunction

  function automatic bit model_idle(input int k);
    return (t[k] < 0) || (t[k] > 4 * per(k));
  endfunction

  // Faulty gate bank: golden response XOR a per-vector fault mask.
  assign y[0] = gold(a[0], b[0]) ^ mask[{a[0], b[0]}];
  assign y[1] = gold(a[1], b[1]) ^ mask[{a[1], b[1]}];

  gate_checker #(.SETTLE_CYCLES(2)) u_dut_s2 (
    .clk_in        (clk),
    .rst_in        (rst),
    .start_in      (start),
    .y_in          (y[0]),
    .a_out         (a[0]),
    .b_out         (b[0]),
    .busy_out      (busy[0]),
    .done_out      (done[0]),
    .pass_out      (pass[0]),
    .err_count_out (errc[0]),
    .fail_vec_out  (fvec[0])
`ifdef GATE_CHECKER_BITMASK_EN
    ,
    .fail_bits_out (fbits[0])
`endif
  );

  gate_checker #(.SETTLE_CYCLES(0)) u_dut_s0 (
    .clk_in        (clk),
    .rst_in        (rst),
    .start_in      (start),
    .y_in          (y[1]),
    .a_out         (a[1]),
    .b_out         (b[1]),
    .busy_out      (busy[1]),
    .done_out      (done[1]),
    .pass_out      (pass[1]),
    .err_count_out (errc[1]),
    .fail_vec_out  (fvec[1])
`ifdef GATE_CHECKER_BITMASK_EN
    ,
    .fail_bits_out (fbits[1])
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference timeline: a run spans edges 0..4P, DONE at 4P, idle afterwards.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        t[k] <= -1;
      end else if (model_idle(k)) begin
        if (start) begin
          t[k] <= 0;
          for (int i = 0; i < 4; i++) snap[k][i] <= mask[i];
        end
      end else begin
        t[k] <= t[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int p, n, v;
      logic e_busy, e_done, e_pass, e_a, e_b;
      logic [2:0] e_err;
      logic [3:0] e_fv;
      logic [6:0] e_fb;
      p      = per(k);
      n      = (t[k] < 0) ? 0 : ((t[k] >= 4 * p) ? 4 : t[k] / p);
      v      = (t[k] < 0) ? 0 : t[k] / p;
      e_busy = (t[k] >= 0) && (t[k] < 4 * p);
      e_done = (t[k] == 4 * p);
      e_a    = e_busy ? v[1] : 1'b0;
      e_b    = e_busy ? v[0] : 1'b0;
      e_err  = '0;
      e_fv   = '0;
      e_fb   = '0;
      for (int i = 0; i < n; i++) begin
        if (snap[k][i] != 7'h0) begin
          e_err   = e_err + 3'd1;
          e_fv[i] = 1'b1;
        end
        e_fb = e_fb | snap[k][i];
      end
      e_pass = (t[k] >= 4 * p) && (e_err == 3'd0);
      chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(e_busy));
      chk($sformatf("done%0d", k), 32'(done[k]), 32'(e_done));
      chk($sformatf("a%0d", k), 32'(a[k]), 32'(e_a));
      chk($sformatf("b%0d", k), 32'(b[k]), 32'(e_b));
      chk($sformatf("pass%0d", k), 32'(pass[k]), 32'(e_pass));
      chk($sformatf("errc%0d", k), 32'(errc[k]), 32'(e_err));
      chk($sformatf("fvec%0d", k), 32'(fvec[k]), 32'(e_fv));
`ifdef GATE_CHECKER_BITMASK_EN
      chk($sformatf("fbits%0d", k), 32'(fbits[k]), 32'(e_fb));
`endif
    end
    if (done[0]) done_cnt++;
  end

  task automatic pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic set_masks(input logic [6:0] m0, input logic [6:0] m1,
                           input logic [6:0] m2, input logic [6:0] m3);
    mask[0] = m0;
    mask[1] = m1;
    mask[2] = m2;
    mask[3] = m3;
  endtask

  initial begin
    set_masks(7'h0, 7'h0, 7'h0, 7'h0);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_pass", 32'(pass[0]), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_hold", 32'(busy[0]), 32'd0);

    // Clean bank: done at edge 4 (settle 0) and edge 12 (settle 2).
    pulse();
    repeat (4) @(negedge clk);
    chk("done_s0_edge4", 32'(done[1]), 32'd1);
    chk("done_s2_not_edge4", 32'(done[0]), 32'd0);
    repeat (8) @(negedge clk);
    chk("done_s2_edge12", 32'(done[0]), 32'd1);
    chk("clean_pass", 32'(pass[0]), 32'd1);
    chk("clean_err", 32'(errc[0]), 32'd0);
    chk("clean_fvec", 32'(fvec[0]), 32'd0);
    chk("clean_pass_s0", 32'(pass[1]), 32'd1);
    repeat (3) @(negedge clk);

    // XOR output stuck at 0: wrong for vectors 01 and 10.
    set_masks(7'h00, 7'h10, 7'h10, 7'h00);
    pulse();
    repeat (14) @(negedge clk);
    chk("xor_fvec", 32'(fvec[0]), 32'b0110);
    chk("xor_err", 32'(errc[0]), 32'd2);
    chk("xor_pass", 32'(pass[0]), 32'd0);
    chk("xor_fvec_s0", 32'(fvec[1]), 32'b0110);
`ifdef GATE_CHECKER_BITMASK_EN
    chk("xor_fbits", 32'(fbits[0]), 32'h10);
`endif

    // NOT-a output inverted: every vector fails.
    set_masks(7'h40, 7'h40, 7'h40, 7'h40);
    pulse();
    repeat (14) @(negedge clk);
    chk("nota_fvec", 32'(fvec[0]), 32'b1111);
    chk("nota_err", 32'(errc[0]), 32'd4);
    chk("nota_pass", 32'(pass[0]), 32'd0);
`ifdef GATE_CHECKER_BITMASK_EN
    chk("nota_fbits", 32'(fbits[0]), 32'h40);
`endif

    // Second start mid-run is ignored; a later start clears and reruns.
    set_masks(7'h0, 7'h0, 7'h0, 7'h0);
    done_cnt = 0;
    pulse();
    repeat (4) @(negedge clk);
    pulse();
    repeat (12) @(negedge clk);
    chk("restart_single_done", 32'(done_cnt), 32'd1);
    chk("restart_pass", 32'(pass[0]), 32'd1);

    // Asynchronous reset while vector 2 is applied.
    set_masks(7'h01, 7'h01, 7'h01, 7'h01);
    done_cnt = 0;
    pulse();
    repeat (6) @(negedge clk);
    chk("vec2_a", 32'(a[0]), 32'd1);
    chk("vec2_b", 32'(b[0]), 32'd0);
    chk("vec2_err", 32'(errc[0]), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy[0]), 32'd0);
    chk("arst_a", 32'(a[0]), 32'd0);
    chk("arst_err", 32'(errc[0]), 32'd0);
    chk("arst_fvec", 32'(fvec[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("arst_no_done", 32'(done_cnt), 32'd0);

    // Random faults, start traffic and occasional mid-cycle resets.
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      rst = 1'b0;
      if (model_idle(0) && model_idle(1) && ($urandom_range(0, 2) == 0)) begin
        for (int i = 0; i < 4; i++)
          mask[i] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'h0;
      end
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: extra cycles each vector is held before y_in is sampled (legal range 0..15).
REQ-002 SHALL have port clk_in  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_in  input  1  run request, sampled in IDLE only.
REQ-005 SHALL have port y_in  input  7  gate-bank response: [0] AND, [1] OR, [2] NAND, [3] NOR, [4] XOR, [5] XNOR, [6] NOT a.
REQ-006 SHALL have port a_out  output  1  stimulus operand a to gate bank.
REQ-007 SHALL have port b_out  output  1  stimulus operand b to gate bank.
REQ-008 SHALL have port busy_out  output  1  high while a run is in progress.
REQ-009 SHALL have port done_out  output  1  one-cycle pulse at end of run.
REQ-010 SHALL have port pass_out  output  1  high when last run had zero mismatches.
REQ-011 SHALL have port err_count_out  output  3  number of failing vectors in last run (0..4).
REQ-012 SHALL have port fail_vec_out  output  4  bit i set when vector i failed.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start_in=1; RUN->DONE after vector 3 sampled; DONE->IDLE unconditionally next edge.
REQ-014 SHALL apply vectors in order i=0..3 with a_out=i[1], b_out=i[0] (00, 01, 10, 11).
REQ-015 SHALL drive vector 0 from the edge accepting start, holding each vector SETTLE_CYCLES+1 cycles; y_in sampled on the last edge of each hold window, next vector applied on that same edge.
REQ-016 SHALL compare sampled y_in against the combinational expected value for the current vector; any bit differing marks the vector failed.
REQ-017 SHALL assert done_out for exactly the one cycle spent in DONE, i.e. after edge 4*(SETTLE_CYCLES+1) counted from the start edge (cycle 12 for default).
REQ-018 SHALL drive a_out=b_out=0 in IDLE and DONE; busy_out=1 only in RUN.
REQ-019 SHALL clear err_count_out, fail_vec_out and pass_out on start acceptance; results SHALL hold from DONE until the next accepted start.
REQ-020 SHALL update pass_out to (err_count==0) on entry to DONE; pass_out=0 during RUN.
REQ-021 SHALL ignore start_in in RUN and DONE (no restart, no queuing).
REQ-022 SHALL sample y_in unsynchronised (gate bank is same-clock combinational logic).

Reset
REQ-023 SHALL on rst_in=1 immediately force IDLE, a_out, b_out, busy_out, done_out, pass_out, err_count_out, fail_vec_out all to 0, including mid-run.
REQ-024 SHALL after rst_in deassertion remain in IDLE until start_in=1.

Configuration
REQ-025 SHALL, when GATE_CHECKER_BITMASK_EN is defined, add output fail_bits_out (7 bits): OR of (sampled y_in XOR expected) across the run, cleared on start and reset, held after DONE.
REQ-026 SHALL, when GATE_CHECKER_BITMASK_EN is undefined, omit fail_bits_out and its logic entirely; all other behaviour identical.

Structure
REQ-027 SHALL place y bit-index constants, NUM_VECTORS=4, FSM state encoding and the expected-response function in shared package gate_check_pkg.
REQ-028 SHALL instantiate one sub-module gate_ref_model (a, b -> 7-bit expected y), usable by benches as a golden model.

Verification
REQ-029 Correct gate bank on y_in, SETTLE_CYCLES=2, start pulse -> done_out high one cycle 12 edges after start edge, err_count_out=0, fail_vec_out=0000, pass_out=1.
REQ-030 y_in[4] stuck at 0 -> fail_vec_out=0110, err_count_out=2, pass_out=0, fail_bits_out=0010000 with macro.
REQ-031 y_in[6] inverted -> fail_vec_out=1111, err_count_out=4, pass_out=0, fail_bits_out=1000000 with macro.
REQ-032 start_in pulsed at cycle 5 of a run -> ignored, single done_out; new start after DONE clears results and reruns.
REQ-033 rst_in asserted while vector 2 applied -> all outputs 0 asynchronously, FSM IDLE, no done_out pulse.
REQ-034 SETTLE_CYCLES=0 -> each vector held one cycle, done_out 4 edges after start edge, results as REQ-029.
